// File: rtl/fc_result_collector.sv
// Collects one FC layer frame and tracks its argmax index.
// Define FC_SIGNED_CMP_EN to make the max search two's-complement signed.
module fc_result_collector #(
  parameter int WORD_SIZE  = 16,
  parameter int LAYER_SIZE = 10,
  localparam int N = $clog2(LAYER_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic [WORD_SIZE-1:0] out_data [LAYER_SIZE],
  output logic [N-1:0]         out_class,
  output logic                 out_valid,
  input  logic                 out_ack
);

  localparam logic [N-1:0] LAST = N'(LAYER_SIZE - 1);

  typedef enum logic {
    COLLECT,
    HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [N-1:0]         idx_q, idx_d;
  logic [WORD_SIZE-1:0] data_q [LAYER_SIZE];
  logic [WORD_SIZE-1:0] data_d [LAYER_SIZE];
  logic [WORD_SIZE-1:0] max_val_q, max_val_d;
  logic [N-1:0]         max_idx_q, max_idx_d;
  logic [N-1:0]         class_q, class_d;
  logic                 out_valid_q, out_valid_d;
  logic                 win;

  function automatic logic greater(
    input logic [WORD_SIZE-1:0] a,
    input logic [WORD_SIZE-1:0] b
  );
`ifdef FC_SIGNED_CMP_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // First word of a frame always wins; ties keep the lower index.
  assign win = (idx_q == '0) || greater(in_data, max_val_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    class_d   = class_q;
    if (flush) begin
      state_d = COLLECT;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (in_valid) begin
            data_d[idx_q] = in_data;
            if (win) begin
              max_val_d = in_data;
              max_idx_d = idx_q;
            end
            if (idx_q == LAST) begin
              state_d = HOLD;
              idx_d   = '0;
              class_d = win ? idx_q : max_idx_q;
            end else begin
              idx_d = idx_q + N'(1);
            end
          end
        end
        HOLD: begin
          if (out_ack) begin
            state_d = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
      class_q     <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < LAYER_SIZE; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      max_val_q   <= max_val_d;
      max_idx_q   <= max_idx_d;
      class_q     <= class_d;
      out_valid_q <= out_valid_d;
      for (int k = 0; k < LAYER_SIZE; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign in_ready  = (state_q == COLLECT) && !rst;
  assign out_valid = out_valid_q;
  assign out_class = class_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_fc_result_collector.sv
// Scoreboard bench for fc_result_collector: random and directed frames
// checked against a frame-level argmax model.
module tb_fc_result_collector;

  localparam int W = 16;
  localparam int L = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] out_data [L];
  logic [3:0]   out_class;
  logic         out_valid;
  logic         out_ack = 1'b0;

  fc_result_collector #(.WORD_SIZE(W), .LAYER_SIZE(L)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_data(out_data), .out_class(out_class),
    .out_valid(out_valid), .out_ack(out_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [W-1:0]   part [$];
  logic [L*W-1:0] exp_data_q [$];
  int             exp_cls_q [$];
  bit             m_hold = 0;
  bit             m_rst = 1;

  logic [L*W-1:0] cur;
  int             cur_cls;
  bit             have_cur = 0;
  bit             prev_valid = 0;

  function automatic bit gt(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef FC_SIGNED_CMP_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  task automatic push_expected();
    logic [L*W-1:0] flat;
    int best;
    best = 0;
    for (int i = 0; i < L; i++) begin
      flat[i*W +: W] = part[i];
      if (i > 0 && gt(part[i], part[best])) best = i;
    end
    exp_data_q.push_back(flat);
    exp_cls_q.push_back(best);
  endtask

  task automatic step(input bit v, input logic [W-1:0] d,
                      input bit f, input bit a, input bit r);
    in_valid = v;
    in_data  = d;
    flush    = f;
    out_ack  = a;
    rst      = r;
    @(posedge clk);
    if (r) begin
      part.delete();
      m_hold = 0;
      m_rst  = 1;
    end else begin
      m_rst = 0;
      if (f) begin
        part.delete();
        m_hold = 0;
      end else if (!m_hold && v) begin
        part.push_back(d);
        if (part.size() == L) begin
          push_expected();
          part.delete();
          m_hold = 1;
        end
      end else if (m_hold && a) begin
        m_hold = 0;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    total++;
    if (in_ready !== (!m_hold && !rst)) begin
      bad++;
      $display("FAIL in_ready: got %b want %b", in_ready, !m_hold && !rst);
    end
    total++;
    if (out_valid !== m_hold) begin
      bad++;
      $display("FAIL out_valid: got %b want %b", out_valid, m_hold);
    end
    if (m_rst) begin
      bit z;
      z = (out_class == 0);
      for (int k = 0; k < L; k++) if (out_data[k] != 0) z = 0;
      total++;
      if (!z) begin
        bad++;
        $display("FAIL reset_zero: class=%0d data0=%h want all zero",
                 out_class, out_data[0]);
      end
    end
    if (out_valid && !prev_valid) begin
      total++;
      if (exp_data_q.size() == 0) begin
        bad++;
        have_cur = 0;
        $display("FAIL unexpected_frame: got out_valid want no frame");
      end else begin
        cur      = exp_data_q.pop_front();
        cur_cls  = exp_cls_q.pop_front();
        have_cur = 1;
      end
    end
    if (out_valid && have_cur) begin
      int bk;
      bk = -1;
      for (int k = L - 1; k >= 0; k--) if (out_data[k] !== cur[k*W +: W]) bk = k;
      total++;
      if (bk >= 0) begin
        bad++;
        $display("FAIL frame_data[%0d]: got %h want %h",
                 bk, out_data[bk], cur[bk*W +: W]);
      end
      total++;
      if (int'(out_class) != cur_cls) begin
        bad++;
        $display("FAIL frame_class: got %0d want %0d", out_class, cur_cls);
      end
    end
    prev_valid = out_valid;
  end

  task automatic ack_frame();
    step(0, '0, 0, 1, 0);
  endtask

  initial begin
    logic [W-1:0] f0 [L];
    f0 = '{16'd3, 16'd7, 16'd1, 16'd9, 16'd2, 16'd9, 16'd0, 16'd4, 16'd5, 16'd6};
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 0);
    for (int i = 0; i < L; i++) step(1, f0[i], 0, 0, 0);
    step(0, '0, 0, 0, 0);
    ack_frame();
    for (int i = 0; i < L; i++) begin
      step(1, f0[i], 0, 0, 0);
      if (i < L - 1) step(0, 16'hdead, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) step(1, W'(100 + i), 0, 0, 0);
    step(1, 16'h00aa, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, W'(20 + i), 0, 0, 0);
    step(1, 16'h0099, 1, 0, 0);
    for (int i = 0; i < L; i++) step(1, 16'h0005, 0, 0, 0);
    step(1, 16'h0001, 1, 1, 0);
    for (int i = 0; i < L; i++) step(1, (i == 2) ? 16'hffff : 16'h0001, 0, 0, 0);
    ack_frame();
    for (int i = 0; i < 4; i++) step(1, W'(50 + i), 0, 0, 0);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 0);
    for (int i = 0; i < L; i++) step(1, W'(i + 1), 0, 0, 0);
    step(0, '0, 0, 0, 0);
    ack_frame();
    for (int c = 0; c < 2000; c++) begin
      bit v, f, a, r;
      logic [W-1:0] d;
      r = ($urandom_range(0, 299) == 0);
      f = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      a = m_hold ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
      d = $urandom_range(0, 1) ? W'($urandom_range(0, 7)) : W'($urandom_range(0, 65535));
      step(v, d, f, a, r);
    end
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    total++;
    if (exp_data_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_frames: got %0d pending want 0", exp_data_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_result_collector.md
FC_RESULT_COLLECTOR -- requirements
Module: fc_result_collector

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, bit width of one FC neuron result.
REQ-002 SHALL have parameter LAYER_SIZE, default 10, number of FC output neurons (classes); N = $clog2(LAYER_SIZE).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous abort of the current frame.
REQ-006 SHALL have port in_valid  input  1  in_data holds a neuron result.
REQ-007 SHALL have port in_ready  output  1  block can accept in_data this cycle.
REQ-008 SHALL have port in_data  input  WORD_SIZE  neuron result, presented in index order 0..LAYER_SIZE-1.
REQ-009 SHALL have port out_data  output  WORD_SIZE x LAYER_SIZE (unpacked array)  collected frame; element k = k-th accepted word, for the downstream argmax stage.
REQ-010 SHALL have port out_class  output  N  index of the maximum element of the frame.
REQ-011 SHALL have port out_valid  output  1  out_data/out_class hold a complete frame.
REQ-012 SHALL have port out_ack  input  1  consumer has taken the frame.

Function
REQ-013 SHALL implement a two-state FSM: COLLECT, HOLD.
REQ-014 In COLLECT, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0; out_valid SHALL be 1 exactly in HOLD (registered).
REQ-015 A word SHALL be accepted when in_valid && in_ready on a rising edge; it SHALL be written to out_data[idx], idx (N bits) then incremented.
REQ-016 Running max: the first word of a frame (idx==0) SHALL load max value and max index unconditionally; later words SHALL replace it only when strictly greater (ties keep the lower index).
REQ-017 Acceptance at idx==LAYER_SIZE-1 SHALL move to HOLD on that edge, clear idx to 0, and present out_class (including that last word's comparison); out_valid SHALL be 1 the cycle after the last accept.
REQ-018 out_data and out_class SHALL stay stable throughout HOLD regardless of in_valid/in_data.
REQ-019 In HOLD, out_ack=1 SHALL return the FSM to COLLECT on that edge; out_ack in COLLECT SHALL be ignored.
REQ-020 flush=1 SHALL force COLLECT and idx=0 on that edge, overriding a simultaneous accept and out_ack; out_data/out_class SHALL keep their last values; the flushed word SHALL be dropped.
REQ-021 No word SHALL be accepted on the cycle out_ack returns the FSM to COLLECT (in_ready is 0 in HOLD); the next frame starts one cycle later.
REQ-022 Non-power-of-two LAYER_SIZE SHALL work; idx SHALL never exceed LAYER_SIZE-1.

Reset
REQ-023 While rst=1: FSM=COLLECT, idx=0, out_valid=0, in_ready=0, out_class=0, all out_data elements=0, max value=0.
REQ-024 rst SHALL override flush, out_ack and accepts; rst asserted mid-frame SHALL discard the partial frame; in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-025 Macro FC_SIGNED_CMP_EN: when defined, REQ-016 comparisons SHALL treat words as two's-complement signed; when undefined, as unsigned. Storage and all other behaviour SHALL be identical either way.

Verification
REQ-026 Reset then stream 10 words 3,7,1,9,2,9,0,4,5,6 with in_valid held high -> out_valid=1 on cycle after 10th accept, out_class=3, out_data[5]=9.
REQ-027 Same frame with in_valid toggled every other cycle -> identical out_data/out_class; out_valid only after 10th accept.
REQ-028 In HOLD, keep in_valid=1 with new data 5 cycles, then out_ack=1 -> outputs unchanged over the 5 cycles, in_ready=0, in_ready=1 next cycle, next frame starts at index 0.
REQ-029 flush asserted together with the 6th accept, then a full frame of all 0x0005 -> flushed word dropped, out_class=0 (ties keep lowest index).
REQ-030 Frame 0xFFFF at index 2, 0x0001 elsewhere -> out_class=2 without FC_SIGNED_CMP_EN; out_class=0 with it defined.
REQ-031 rst pulsed after 4 accepts -> out_valid=0, out_data all zero, then a full frame of 1..10 -> out_class=9.
